// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - strobe bus between the bus interface and the SPI master sequencer
//
// Signals:
//   dout  [10:0] configuration or transmit word
//   cmd          one-cycle pulse: write configuration from dout
//   wr           one-cycle pulse: queue transmit byte from dout
//   rd           one-cycle pulse: read receive register
//   din   [8:0]  {rx_valid, rx_data}, meaningful while ack=1
//   ack          one-cycle completion pulse
// Modports: master (bus interface side), slave (sequencer side).

interface spi_master_ctrl_if;
    logic [10:0] dout;
    logic        cmd;
    logic        wr;
    logic        rd;
    logic [8:0]  din;
    logic        ack;

    modport master (
        output dout, cmd, wr, rd,
        input  din, ack
    );

    modport slave (
        input  dout, cmd, wr, rd,
        output din, ack
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - byte-oriented SPI master sequencer
//
// Holds the SPI configuration, buffers one transmit byte, runs the 8-bit shift
// sequence and captures each received byte for readback.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   bus       strobe bus (slave modport): dout/cmd/wr/rd in, din/ack out
//   busy      shift sequence active or holding register full
//   spi_sck   SPI clock, idles at CPOL
//   spi_mosi  SPI data out, MSB first
//   spi_miso  SPI data in
//   spi_cs_n  chip select, active-low
//
// Optional feature macro: SPI_LOOPBACK_EN (cmd dout[10] selects internal
// MOSI->receive loopback).

module spi_master_ctrl #(
    parameter logic [7:0] DIV_RESET  = 8'd3,
    parameter logic       CPOL_RESET = 1'b0,
    parameter logic       CPHA_RESET = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_ctrl_if.slave   bus,
    output logic               busy,
    output logic               spi_sck,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic               spi_cs_n
);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_CMD, REQ_WR, REQ_RD} req_t;

    state_t      state;
    state_t      state_next;

    // configuration
    logic [7:0]  div_q;
    logic        cpol_q;
    logic        cpha_q;

    // holding register
    logic        hold_full;
    logic [7:0]  hold_data;
    logic        hold_keep;

    // shift datapath
    logic [7:0]  tx_sh;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_next;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        keep_cur;
    logic [7:0]  cnt;
    logic [3:0]  edge_cnt;     // SCK edges already issued; bit counter is edge_cnt[3:1]
    logic        sck_q;
    logic        mosi_q;
    logic        cs_n_q;
    logic        miso_in;

    // request handling
    req_t        pend_q;
    logic [10:0] pend_dout;
    req_t        req_kind;
    logic [10:0] req_dout;
    logic        serve;
    logic        ack_q;
    logic [8:0]  din_q;

    // FSM control strobes
    logic        tick;
    logic        take;
    logic        do_edge;
    logic        sample_edge;
    logic        shift_done;
    logic        trail_end;

`ifdef SPI_LOOPBACK_EN
    logic        loop_q;
    assign miso_in = loop_q ? mosi_q : spi_miso;
`else
    logic        unused_rsvd;
    assign unused_rsvd = req_dout[10];
    assign miso_in     = spi_miso;
`endif

    assign bus.din  = din_q;
    assign bus.ack  = ack_q;
    assign busy     = (state != IDLE) || hold_full;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

    assign tick = (cnt == div_q);

    // The current request is the pending one if any, otherwise a fresh strobe;
    // a fresh strobe that cannot be served right away is parked in pend_q.
    always_comb begin
        req_kind = pend_q;
        req_dout = pend_dout;
        if (pend_q == REQ_NONE) begin
            req_dout = bus.dout;
            if (bus.cmd)
                req_kind = REQ_CMD;
            else if (bus.wr)
                req_kind = REQ_WR;
            else if (bus.rd)
                req_kind = REQ_RD;
        end
    end

    // Configuration changes only while nothing is queued or shifting.
    always_comb begin
        serve = 1'b0;
        case (req_kind)
            REQ_CMD: serve = (state == IDLE) && !hold_full;
            REQ_WR:  serve = !hold_full;
            REQ_RD:  serve = 1'b1;
            default: serve = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        do_edge    = 1'b0;
        shift_done = 1'b0;
        trail_end  = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_next = LEAD;
                    take       = 1'b1;
                end
            end
            LEAD: begin
                if (tick)
                    state_next = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    do_edge = 1'b1;
                    if (edge_cnt == 4'd15) begin
                        state_next = TRAIL;
                        shift_done = 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    trail_end = 1'b1;
                    if (keep_cur && hold_full) begin
                        state_next = LEAD;
                        take       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Edge number edge_cnt+1 is odd when edge_cnt[0]=0. CPHA=0 samples on odd
    // edges, CPHA=1 on even edges; the other edges shift MOSI.
    assign sample_edge = do_edge && (cpha_q ? edge_cnt[0] : !edge_cnt[0]);
    assign rx_next     = sample_edge ? {rx_sh[6:0], miso_in} : rx_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= DIV_RESET;
            cpol_q    <= CPOL_RESET;
            cpha_q    <= CPHA_RESET;
`ifdef SPI_LOOPBACK_EN
            loop_q    <= 1'b0;
`endif
            hold_full <= 1'b0;
            hold_data <= 8'h00;
            hold_keep <= 1'b0;
            tx_sh     <= 8'h00;
            rx_sh     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            keep_cur  <= 1'b0;
            cnt       <= 8'h00;
            edge_cnt  <= 4'h0;
            sck_q     <= CPOL_RESET;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            pend_q    <= REQ_NONE;
            pend_dout <= 11'h000;
            ack_q     <= 1'b0;
            din_q     <= 9'h000;
        end else begin
            ack_q <= 1'b0;

            if (state == IDLE || tick)
                cnt <= 8'h00;
            else
                cnt <= cnt + 8'd1;

            // CPHA=0 needs bit 7 on MOSI before the first edge, so it is
            // presented at load and the shifter starts at bit 6.
            if (take) begin
                tx_sh     <= cpha_q ? hold_data : {hold_data[6:0], 1'b0};
                mosi_q    <= hold_data[7];
                keep_cur  <= hold_keep;
                hold_full <= 1'b0;
                cs_n_q    <= 1'b0;
                edge_cnt  <= 4'h0;
            end

            if (do_edge) begin
                sck_q    <= ~sck_q;
                edge_cnt <= edge_cnt + 4'd1;
                rx_sh    <= rx_next;
                if (!sample_edge) begin
                    mosi_q <= tx_sh[7];
                    tx_sh  <= {tx_sh[6:0], 1'b0};
                end
            end

            // keep_cs holds CS through TRAIL; CS is always released on return to IDLE.
            if (shift_done && !keep_cur)
                cs_n_q <= 1'b1;
            if (trail_end && state_next == IDLE)
                cs_n_q <= 1'b1;

            if (req_kind != REQ_NONE) begin
                if (serve) begin
                    ack_q  <= 1'b1;
                    pend_q <= REQ_NONE;
                    case (req_kind)
                        REQ_CMD: begin
                            div_q  <= req_dout[7:0];
                            cpol_q <= req_dout[8];
                            cpha_q <= req_dout[9];
                            sck_q  <= req_dout[8];
`ifdef SPI_LOOPBACK_EN
                            loop_q <= req_dout[10];
`endif
                        end
                        REQ_WR: begin
                            hold_full <= 1'b1;
                            hold_data <= req_dout[7:0];
                            hold_keep <= req_dout[8];
                        end
                        REQ_RD: begin
                            din_q    <= {rx_valid, rx_data};
                            rx_valid <= 1'b0;
                        end
                        default: ;
                    endcase
                end else begin
                    pend_q    <= req_kind;
                    pend_dout <= req_dout;
                end
            end

            // Completion overrides a same-cycle read clear.
            if (shift_done) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl

module tb_spi_master_ctrl;

    localparam int BOUND = 3000;
    localparam int K_CMD = 0;
    localparam int K_WR  = 1;
    localparam int K_RD  = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic spi_sck;
    logic spi_mosi;
    logic spi_miso;
    logic spi_cs_n;

    spi_master_ctrl_if bus();

    spi_master_ctrl #(
        .DIV_RESET  (8'd3),
        .CPOL_RESET (1'b0),
        .CPHA_RESET (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int req_cnt = 0;

    // SPI slave / line monitor state
    int         cyc = 0;
    logic       sck_prev = 1'b0;
    logic       cs_prev = 1'b1;
    int         toggles = 0;
    int         gaps[$];
    int         last_toggle = 0;
    bit         have_toggle = 0;
    int         sbit = 0;
    logic [7:0] slave_tx[$];
    logic [7:0] mosi_cap = 8'h00;
    logic [7:0] mosi_bytes[$];
    int         ack_cnt = 0;
    int         cs_falls = 0;
    logic       cur_cpol = 1'b0;
    logic       cur_cpha = 1'b0;

    // Behavioural SPI slave: a sample edge is a leading edge in CPHA=0 and a
    // trailing edge in CPHA=1; MISO presents the next unsent bit of the front byte.
    always @(negedge clk) begin
        cyc++;
        if (bus.ack === 1'b1) ack_cnt++;
        if (cs_prev && !spi_cs_n) cs_falls++;
        cs_prev = spi_cs_n;
        if (spi_sck !== sck_prev) begin
            toggles++;
            if (have_toggle) gaps.push_back(cyc - last_toggle);
            last_toggle = cyc;
            have_toggle = 1;
            if ((spi_sck != cur_cpol) != cur_cpha) begin
                mosi_cap = {mosi_cap[6:0], spi_mosi};
                sbit++;
                if (sbit == 8) begin
                    mosi_bytes.push_back(mosi_cap);
                    sbit = 0;
                    if (slave_tx.size() > 0) void'(slave_tx.pop_front());
                end
            end
        end
        sck_prev = spi_sck;
        if (spi_cs_n) sbit = 0;
        spi_miso = (slave_tx.size() > 0) ? slave_tx[0][7 - sbit] : 1'b0;
    end

    task automatic clear_mon();
        @(negedge clk);
        #1;
        toggles = 0;
        gaps.delete();
        have_toggle = 0;
        mosi_bytes.delete();
        slave_tx.delete();
        sbit = 0;
    endtask

    task automatic bus_req(input int kind, input logic [10:0] val,
                           output int lat, output logic [8:0] rdata);
        @(negedge clk);
        bus.dout = val;
        bus.cmd  = (kind == K_CMD);
        bus.wr   = (kind == K_WR);
        bus.rd   = (kind == K_RD);
        @(negedge clk);
        bus.cmd = 1'b0;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        lat   = 0;
        rdata = 9'h000;
        for (int i = 1; i <= BOUND; i++) begin
            if (bus.ack === 1'b1) begin
                lat   = i;
                rdata = bus.din;
                break;
            end
            @(negedge clk);
        end
        if (lat > 0) req_cnt++;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Shared scenario body: one byte out with a random slave byte back.
    task automatic xfer_check(input string tag, input logic [10:0] wdout,
                              input logic [7:0] sbyte, input int half);
        int lat;
        int bad;
        bit ok;
        logic [8:0] rdata;
        slave_tx.push_back(sbyte);
        bus_req(K_WR, wdout, lat, rdata);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL %s wr_ack_latency: got %0d expected 1", tag, lat); end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s idle_timeout: busy still high after %0d cycles", tag, BOUND); end
        checks++;
        if (mosi_bytes.size() != 1 || mosi_bytes[0] !== wdout[7:0]) begin
            errors++;
            $display("FAIL %s mosi_byte: got %0h (n=%0d) expected %0h", tag,
                     (mosi_bytes.size() > 0) ? mosi_bytes[0] : 8'hxx, mosi_bytes.size(), wdout[7:0]);
        end
        checks++;
        if (toggles != 16) begin errors++; $display("FAIL %s sck_edges: got %0d expected 16", tag, toggles); end
        bad = 0;
        foreach (gaps[i]) if (gaps[i] != half) bad++;
        checks++;
        if (bad != 0 || gaps.size() != 15) begin
            errors++;
            $display("FAIL %s sck_half_period: %0d of %0d gaps wrong, expected all %0d", tag, bad, gaps.size(), half);
        end
        checks++;
        if (spi_cs_n !== 1'b1 || spi_sck !== cur_cpol) begin
            errors++;
            $display("FAIL %s idle_pins: cs_n=%b sck=%b expected cs_n=1 sck=%b", tag, spi_cs_n, spi_sck, cur_cpol);
        end
        bus_req(K_RD, 11'h000, lat, rdata);
        checks++;
        if (lat !== 1 || rdata !== {1'b1, sbyte}) begin
            errors++;
            $display("FAIL %s rd_data: got %h lat %0d expected %h lat 1", tag, rdata, lat, {1'b1, sbyte});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.dout = 11'h000;
        bus.cmd = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
        checks++;
        if (bus.din !== 9'h000) begin errors++; $display("FAIL reset_din: got %h expected 000", bus.din); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (spi_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", spi_sck); end
        checks++;
        if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", spi_mosi); end
        checks++;
        if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", spi_cs_n); end
        rst = 1'b0;
    endtask

    task automatic test_mode0();
        int lat;
        logic [8:0] rdata;
        bus_req(K_CMD, 11'h001, lat, rdata);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL cmd_ack_latency: got %0d expected 1", lat); end
        checks++;
        if (spi_sck !== 1'b0 || spi_cs_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cmd_pins: sck=%b cs_n=%b busy=%b expected 0 1 0", spi_sck, spi_cs_n, busy);
        end
        cur_cpol = 1'b0;
        cur_cpha = 1'b0;
        clear_mon();
        xfer_check("mode0", 11'h0A5, 8'h3C, 2);
        bus_req(K_RD, 11'h000, lat, rdata);
        checks++;
        if (rdata !== 9'h03C) begin errors++; $display("FAIL second_rd: got %h expected 03c", rdata); end
    endtask

    task automatic test_back_to_back();
        int lat2;
        int falls0;
        bit ok;
        bit ack1;
        int lat;
        logic [8:0] rdata;
        logic [7:0] s1;
        logic [7:0] s2;
        s1 = 8'($urandom);
        s2 = 8'($urandom);
        clear_mon();
        slave_tx.push_back(s1);
        slave_tx.push_back(s2);
        falls0 = cs_falls;
        @(negedge clk);
        bus.dout = 11'h1FF;
        bus.wr = 1'b1;
        @(negedge clk);
        ack1 = bus.ack;
        bus.dout = 11'h155;
        bus.wr = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0;
        checks++;
        if (ack1 !== 1'b1) begin errors++; $display("FAIL b2b_first_ack: got %b expected 1", ack1); end
        else req_cnt++;
        lat2 = 0;
        for (int i = 1; i <= BOUND; i++) begin
            if (bus.ack === 1'b1) begin lat2 = i; break; end
            @(negedge clk);
        end
        if (lat2 > 0) req_cnt++;
        checks++;
        if (lat2 < 2 || spi_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_ack_deferred: latency %0d cs_n %b, expected latency >=2 with cs_n 0", lat2, spi_cs_n);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_idle_timeout: busy still high"); end
        checks++;
        if (cs_falls - falls0 != 1 || spi_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL b2b_cs_held: cs falls %0d cs_n %b, expected 1 fall and cs_n 1", cs_falls - falls0, spi_cs_n);
        end
        checks++;
        if (mosi_bytes.size() != 2 || mosi_bytes[0] !== 8'hFF || mosi_bytes[1] !== 8'h55) begin
            errors++;
            $display("FAIL b2b_mosi: got %0d bytes, expected ff then 55", mosi_bytes.size());
        end
        bus_req(K_RD, 11'h000, lat, rdata);
        checks++;
        if (rdata !== {1'b1, s2}) begin errors++; $display("FAIL b2b_rd: got %h expected %h", rdata, {1'b1, s2}); end
    endtask

    task automatic test_cfg_deferred();
        int lat;
        logic [8:0] rdata;
        logic [7:0] t1;
        t1 = 8'($urandom);
        clear_mon();
        slave_tx.push_back(8'($urandom));
        bus_req(K_WR, {3'b000, t1}, lat, rdata);
        bus_req(K_CMD, 11'h300, lat, rdata);
        checks++;
        if (lat < 2 || busy !== 1'b0 || spi_sck !== 1'b1) begin
            errors++;
            $display("FAIL cfg_deferred_ack: latency %0d busy %b sck %b, expected >=2 0 1", lat, busy, spi_sck);
        end
        checks++;
        if (mosi_bytes.size() < 1 || mosi_bytes[0] !== t1) begin
            errors++;
            $display("FAIL cfg_first_byte: got %0d bytes, expected first %h", mosi_bytes.size(), t1);
        end
        cur_cpol = 1'b1;
        cur_cpha = 1'b1;
        clear_mon();
        checks++;
        if (spi_sck !== 1'b1) begin errors++; $display("FAIL cfg_sck_idle: got %b expected 1", spi_sck); end
        xfer_check("mode3", {3'b000, 8'($urandom)}, 8'($urandom), 1);
    endtask

    task automatic test_reset_mid();
        int lat;
        int acks0;
        bit seen;
        logic [8:0] rdata;
        clear_mon();
        bus_req(K_WR, 11'h0FF, lat, rdata);
        seen = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (toggles > 0) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_no_shift: no SCK edge within %0d cycles", BOUND); end
        bus.dout = 11'h002;
        bus.cmd = 1'b1;
        @(negedge clk);
        bus.cmd = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acks0 = ack_cnt;
        cur_cpol = 1'b0;
        cur_cpha = 1'b0;
        checks++;
        if (spi_cs_n !== 1'b1 || busy !== 1'b0 || bus.ack !== 1'b0 || spi_sck !== 1'b0 || spi_mosi !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pins: cs_n=%b busy=%b ack=%b sck=%b mosi=%b expected 1 0 0 0 0",
                     spi_cs_n, busy, bus.ack, spi_sck, spi_mosi);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (ack_cnt != acks0) begin errors++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", ack_cnt - acks0); end
        bus_req(K_RD, 11'h000, lat, rdata);
        checks++;
        if (rdata !== 9'h000 || lat !== 1) begin errors++; $display("FAIL rstmid_rd: got %h lat %0d expected 000 lat 1", rdata, lat); end
    endtask

    task automatic test_random();
        int lat;
        logic [8:0] rdata;
        logic [7:0] dv;
        logic cp;
        logic ch;
        for (int n = 0; n < 6; n++) begin
            dv = 8'($urandom_range(0, 3));
            cp = 1'($urandom);
            ch = 1'($urandom);
            bus_req(K_CMD, {1'b0, ch, cp, dv}, lat, rdata);
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL rand%0d cmd_latency: got %0d expected 1", n, lat); end
            cur_cpol = cp;
            cur_cpha = ch;
            clear_mon();
            xfer_check($sformatf("rand%0d", n), {2'($urandom), 1'b0, 8'($urandom)}, 8'($urandom), int'(dv) + 1);
        end
    endtask

    task automatic test_loopback();
        int lat;
        logic [8:0] rdata;
        logic [8:0] expv;
        bit ok;
`ifdef SPI_LOOPBACK_EN
        expv = 9'h15A;
`else
        expv = 9'h1C3;
`endif
        bus_req(K_CMD, 11'h400, lat, rdata);
        cur_cpol = 1'b0;
        cur_cpha = 1'b0;
        clear_mon();
        slave_tx.push_back(8'hC3);
        bus_req(K_WR, 11'h05A, lat, rdata);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL loop_idle_timeout: busy still high"); end
        bus_req(K_RD, 11'h000, lat, rdata);
        checks++;
        if (rdata !== expv) begin errors++; $display("FAIL loopback_rd: got %h expected %h", rdata, expv); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_back_to_back();
        test_cfg_deferred();
        test_reset_mid();
        test_random();
        test_loopback();
        repeat (3) @(negedge clk);
        checks++;
        if (ack_cnt != req_cnt) begin errors++; $display("FAIL ack_count: got %0d acks expected %0d", ack_cnt, req_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Byte-oriented SPI master sequencer. It sits behind the Wishbone slave interface and consumes that interface's internal strobe bus (dout/cmd/wr/rd, returning din/ack).
- Holds the SPI configuration, buffers one transmit byte, runs the 8-bit shift state machine, and drives spi_sck, spi_mosi and spi_cs_n.
- Captures each received byte for readback.

Parameters:
- DIV_RESET, 8'd3: reset value of the clock divider. SCK half-period = (div+1) clk cycles.
- CPOL_RESET, 1'b0: reset value of CPOL.
- CPHA_RESET, 1'b0: reset value of CPHA.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- dout  in  11  configuration or transmit word from the bus interface.
- cmd  in  1  one-cycle pulse: write configuration from dout.
- wr  in  1  one-cycle pulse: queue transmit byte from dout.
- rd  in  1  one-cycle pulse: read receive register.
- din  out  9  {rx_valid, rx_data[7:0]}; meaningful only while ack=1.
- ack  out  1  one-cycle completion pulse for the pending cmd, wr or rd.
- busy  out  1  high while the shift FSM is not IDLE or the holding register is full.
- spi_sck  out  1  SPI clock.
- spi_mosi  out  1  SPI data out, MSB first.
- spi_miso  in  1  SPI data in.
- spi_cs_n  out  1  chip select, active-low.

Behaviour:
- Reset values: ack=0, din=0, busy=0, spi_sck=CPOL_RESET, spi_mosi=0, spi_cs_n=1. Also div=DIV_RESET, holding register empty, rx_valid=0, FSM=IDLE, no pending request.
- Requests:
  - cmd/wr/rd pulses are latched into a single pending-request register. Only one is outstanding at a time, because the bus holds the cycle until ack.
  - Exactly one ack pulse is issued per request.
  - Any strobe arriving while a request is pending is ignored.
- cmd:
  - Field map: dout[7:0]=div, [8]=CPOL, [9]=CPHA, [10]=reserved.
  - Applied, and acked, only when FSM=IDLE and the holding register is empty; otherwise deferred.
  - Earliest ack is the cycle after the cmd pulse.
  - spi_sck takes the new CPOL level in the same cycle the configuration is applied.
- wr:
  - Field map: dout[7:0]=data, dout[8]=keep_cs (leave CS asserted after this byte), dout[10:9] ignored.
  - Acked the cycle the byte enters the holding register. If the holding register is full, the ack is deferred until the FSM takes the byte.
- rd:
  - Acked the cycle after the pulse, with din={rx_valid, rx_data}.
  - The read clears rx_valid.
  - If a byte completes in the same cycle, din returns the old value and rx_valid ends at 1 (completion wins).
- FSM states: IDLE, LEAD, SHIFT, TRAIL.
  - IDLE→LEAD: holding register full. The byte loads into the shift register, the holding register empties, and spi_cs_n goes to 0.
  - LEAD: lasts div+1 cycles of CS setup.
  - SHIFT: 16 SCK edges, each separated by div+1 clk cycles.
    - CPHA=0: MOSI is valid before the first edge; sample on odd edges, shift on even edges.
    - CPHA=1: shift on odd edges, sample on even edges.
    - Bit counter runs 0..7.
  - SHIFT→TRAIL: after the 16th edge. rx_data is updated and rx_valid=1; if rx_valid was already 1, the old data is overwritten.
  - TRAIL: lasts div+1 cycles, then goes to IDLE.
    - spi_cs_n=1 unless the byte's keep_cs=1.
    - If the holding register is full at TRAIL end and keep_cs=1, go directly to LEAD for back-to-back bytes, with CS held low.
- spi_sck idles at CPOL outside SHIFT.
- div=0 gives SCK = clk/2.
- rst mid-transfer: everything returns to reset values the next cycle. The pending request and holding byte are discarded and no ack is issued.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: cmd dout[10] sets a loopback bit (reset 0). While the bit is set, the shift register samples spi_mosi internally instead of spi_miso, and the spi_sck/spi_mosi/spi_cs_n pins still toggle normally.
- Undefined: dout[10] is ignored, and spi_miso is always sampled.

Test Plan:
1. Reset, then cmd dout=11'h001 (div=1, mode 0) → ack one cycle after the pulse; spi_sck=0, spi_cs_n=1, busy=0.
2. wr dout=11'h0A5 with spi_miso tied to an external slave returning 8'h3C → ack the next cycle.
   - MOSI shows bits 1,0,1,0,0,1,0,1; 8 SCK periods, each 4 clk long; CS returns high.
   - A following rd returns din=9'h13C; a second rd returns din=9'h03C.
3. Two wr with keep_cs=1 (11'h1FF then 11'h155) → the second ack is deferred until the first byte leaves the holding register; spi_cs_n stays 0 across both bytes, then goes 1.
4. cmd dout=11'h300 (CPOL=1, CPHA=1, div=0) issued during a transfer → ack only after IDLE; the next byte shows SCK idling high and SCK period = 2 clk.
5. Assert rst during SHIFT of wr 11'h0FF → next cycle spi_cs_n=1, busy=0, no ack; a following rd returns 9'h000.
6. With SPI_LOOPBACK_EN defined: cmd 11'h400, then wr 11'h05A, then rd → din=9'h15A regardless of spi_miso.
